// File: rtl/gate_stim_seq_if.sv
// Bundle for the gate stimulus/capture sequencer: control inputs, the gate
// result bus coming back, and the stimulus/capture/status outputs.
// slave = sequencer side, master = controller/testbench side.
interface gate_stim_seq_if;
   logic       start;
   logic       auto_mode;
   logic       btn_step;
   logic [6:0] y_in;
   logic       a;
   logic       b;
   logic [1:0] vec_idx;
   logic       cap_valid;
   logic [6:0] cap_data;
   logic       busy;
   logic       done;
   logic       mismatch;

   modport slave (
      input  start, auto_mode, btn_step, y_in,
      output a, b, vec_idx, cap_valid, cap_data, busy, done, mismatch
   );

   modport master (
      output start, auto_mode, btn_step, y_in,
      input  a, b, vec_idx, cap_valid, cap_data, busy, done, mismatch
   );
endinterface

// File: rtl/gate_stim_seq.sv
// Stimulus/capture sequencer for the two-input gate bank.
// Walks {a,b} through 00,01,10,11, lets each vector settle, captures the
// 7-bit gate result, then waits for a timed tick (auto) or a debounced
// button press (manual) before moving on.
// Optional feature macro: SELFCHECK_EN -- compares each capture against the
// ideal gate truth table and raises a sticky mismatch flag.
module gate_stim_seq #(
   parameter int STEP_DIV   = 50_000_000,
   parameter int DB_CYCLES  = 1_000_000,
   parameter int SETTLE_CYC = 2
) (
   input  logic           clk,
   input  logic           rst,
   gate_stim_seq_if.slave bus
);

   localparam int TW = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
   localparam int DW = (DB_CYCLES  > 1) ? $clog2(DB_CYCLES)  : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [TW-1:0] TICK_MAX   = TW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DB_MAX     = DW'(DB_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      vec_q;
   logic            mode_q;
   logic            busy_q;
   logic            done_q;
   logic            cap_valid_q;
   logic [6:0]      cap_data_q;
   logic [SW-1:0]   settle_cnt_q;
   logic [TW-1:0]   tick_cnt_q;
   logic            btn_s1_q, btn_s2_q;
   logic            db_lvl_q;
   logic [DW-1:0]   db_cnt_q;
   logic            step_q;

   logic            tick;
   logic            start_acc;
   logic            enter_settle;
   logic            advance;
   logic            finish;

   assign tick = (tick_cnt_q == TICK_MAX);

   // Button: two-flop synchroniser, then a level is accepted only after it
   // has differed from the accepted level for DB_CYCLES samples in a row.
   // A newly accepted high level produces a single-cycle step strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
         db_lvl_q <= 1'b0;
         db_cnt_q <= '0;
         step_q   <= 1'b0;
      end else begin
         btn_s1_q <= bus.btn_step;
         btn_s2_q <= btn_s1_q;
         step_q   <= 1'b0;
         if (btn_s2_q == db_lvl_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_MAX) begin
            db_cnt_q <= '0;
            db_lvl_q <= btn_s2_q;
            step_q   <= btn_s2_q;
         end else begin
            db_cnt_q <= db_cnt_q + DW'(1);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state plus the strobes that steer the datapath registers.
   always_comb begin
      state_d      = state_q;
      start_acc    = 1'b0;
      enter_settle = 1'b0;
      advance      = 1'b0;
      finish       = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               start_acc    = 1'b1;
               enter_settle = 1'b1;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_cnt_q == SETTLE_MAX) state_d = S_CAPTURE;
         end
         S_CAPTURE: state_d = S_WAIT;
         S_WAIT: begin
            if (mode_q ? tick : step_q) begin
               if (vec_q == 2'd3) begin
                  finish  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  advance      = 1'b1;
                  enter_settle = 1'b1;
                  state_d      = S_SETTLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Vector index, latched mode and busy/done status.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q  <= 2'd0;
         mode_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         if (start_acc) begin
            vec_q  <= 2'd0;
            mode_q <= bus.auto_mode;
            busy_q <= 1'b1;
            done_q <= 1'b0;
         end else if (advance) begin
            vec_q <= vec_q + 2'd1;
         end else if (finish) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   // Settle and step timers; both restart whenever a vector is (re)applied
   // so every vector gets the full settle time and a full auto interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt_q <= '0;
         tick_cnt_q   <= '0;
      end else begin
         if (enter_settle)           settle_cnt_q <= '0;
         else if (state_q == S_SETTLE) settle_cnt_q <= settle_cnt_q + SW'(1);

         if (enter_settle || tick) tick_cnt_q <= '0;
         else                      tick_cnt_q <= tick_cnt_q + TW'(1);
      end
   end

   // Capture register: data and valid strobe update on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_valid_q <= 1'b0;
         cap_data_q  <= '0;
      end else begin
         cap_valid_q <= (state_q == S_CAPTURE);
         if (state_q == S_CAPTURE) cap_data_q <= bus.y_in;
      end
   end

`ifdef SELFCHECK_EN
   logic       mismatch_q;
   logic       exp_a, exp_b;
   logic [6:0] y_exp;

   assign exp_a = vec_q[1];
   assign exp_b = vec_q[0];
   assign y_exp = {~exp_a, ~(exp_a ^ exp_b), exp_a ^ exp_b, ~(exp_a | exp_b),
                   ~(exp_a & exp_b), exp_a | exp_b, exp_a & exp_b};

   // Sticky miscompare flag, cleared when a new sweep is accepted.
   always_ff @(posedge clk) begin
      if (rst)                                          mismatch_q <= 1'b0;
      else if (start_acc)                               mismatch_q <= 1'b0;
      else if (state_q == S_CAPTURE && bus.y_in != y_exp) mismatch_q <= 1'b1;
   end

   assign bus.mismatch = mismatch_q;
`else
   assign bus.mismatch = 1'b0;
`endif

   assign bus.a         = vec_q[1];
   assign bus.b         = vec_q[0];
   assign bus.vec_idx   = vec_q;
   assign bus.cap_valid = cap_valid_q;
   assign bus.cap_data  = cap_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_gate_stim_seq.sv
// Directed bench for gate_stim_seq: reset, auto sweep against a golden gate
// model, self-check flag, debounced manual stepping, start-while-busy and
// mid-sweep reset.
module tb_gate_stim_seq;

   logic clk = 1'b0;
   logic rst;
   logic fault_en;
   int   n_run  = 0;
   int   n_fail = 0;

`ifdef SELFCHECK_EN
   localparam logic MM_EXP = 1'b1;
`else
   localparam logic MM_EXP = 1'b0;
`endif

   gate_stim_seq_if ifc();

   gate_stim_seq #(.STEP_DIV(4), .DB_CYCLES(8), .SETTLE_CYC(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   // Golden gate bank, with an optional stuck-at-1 fault on the AND output at vector 00.
   assign ifc.y_in = {~ifc.a, ~(ifc.a ^ ifc.b), ifc.a ^ ifc.b, ~(ifc.a | ifc.b),
                      ~(ifc.a & ifc.b), ifc.a | ifc.b,
                      (ifc.a & ifc.b) | (fault_en && ifc.vec_idx == 2'd0)};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      cyc(1);
      ifc.start = 1'b0;
   endtask

   // Collect up to four captures; a stray start is pulsed after the second.
   task automatic sweep(output logic [3:0][6:0] got, output int n, output logic mm0);
      n   = 0;
      got = '0;
      mm0 = 1'b0;
      for (int c = 0; c < 300 && n < 4; c++) begin
         cyc(1);
         ifc.start = 1'b0;
         if (ifc.cap_valid) begin
            got[n[1:0]] = ifc.cap_data;
            if (n == 0) mm0 = ifc.mismatch;
            n++;
            if (n == 2) ifc.start = 1'b1;
         end
      end
      ifc.start = 1'b0;
   endtask

   task automatic wait_done(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         cyc(1);
         if (ifc.done) ok = 1'b1;
      end
   endtask

   task automatic wait_cap(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         cyc(1);
         if (ifc.cap_valid) ok = 1'b1;
      end
   endtask

   task automatic run_count(input int n, output int caps);
      caps = 0;
      repeat (n) begin
         cyc(1);
         if (ifc.cap_valid) caps++;
      end
   endtask

   initial begin
      logic [3:0][6:0] got;
      int              n;
      int              caps;
      int              caps_tog;
      logic            mm0;
      logic            ok;

      // Reset with random control inputs.
      fault_en      = 1'b0;
      rst           = 1'b1;
      ifc.start     = 1'($urandom);
      ifc.auto_mode = 1'($urandom);
      ifc.btn_step  = 1'($urandom);
      cyc(3);
      chk("rst_ab_vec",  {ifc.a, ifc.b, ifc.vec_idx}, 0);
      chk("rst_cap",     {ifc.cap_valid, ifc.cap_data}, 0);
      chk("rst_status",  {ifc.busy, ifc.done, ifc.mismatch}, 0);
      rst           = 1'b0;
      ifc.start     = 1'b0;
      ifc.btn_step  = 1'b0;
      ifc.auto_mode = 1'b1;
      cyc(1);

      // Auto sweep against the golden gate model.
      pulse_start();
      chk("auto_busy", ifc.busy, 1);
      chk("auto_vec0", ifc.vec_idx, 0);
      sweep(got, n, mm0);
      chk("auto_ncap", n, 4);
      chk("auto_cap0", got[0], 7'h6C);
      chk("auto_cap1", got[1], 7'h56);
      chk("auto_cap2", got[2], 7'h16);
      chk("auto_cap3", got[3], 7'h23);
      chk("auto_mm",   mm0, 0);
      wait_done(ok);
      chk("auto_done_seen", ok, 1);
      chk("auto_busy_off",  ifc.busy, 0);
      chk("auto_ab_hold",   {ifc.a, ifc.b, ifc.vec_idx}, 4'hF);
      cyc(10);
      chk("auto_no_wrap",   ifc.vec_idx, 3);
      chk("auto_done_stk",  ifc.done, 1);

      // Self-check: faulty AND output at vector 00.
      fault_en = 1'b1;
      pulse_start();
      chk("mm_done_clr", ifc.done, 0);
      sweep(got, n, mm0);
      fault_en = 1'b0;
      chk("mm_ncap",  n, 4);
      chk("mm_cap0",  got[0], 7'h6D);
      chk("mm_first", mm0, MM_EXP);
      wait_done(ok);
      chk("mm_done_seen", ok, 1);
      chk("mm_sticky",    ifc.mismatch, MM_EXP);

      // Manual sweep; auto_mode flipped after start must not matter.
      ifc.auto_mode = 1'b0;
      pulse_start();
      ifc.auto_mode = 1'b1;
      chk("man_mm_clr", ifc.mismatch, 0);
      chk("man_status", {ifc.busy, ifc.done}, 2'b10);
      wait_cap(ok);
      chk("man_cap0_seen", ok, 1);
      caps_tog = 0;
      repeat (10) begin
         ifc.btn_step = ~ifc.btn_step;
         run_count(3, caps);
         caps_tog += caps;
      end
      chk("man_bounce_noadv", ifc.vec_idx, 0);
      ifc.btn_step = 1'b1;
      run_count(40, caps);
      chk("man_step1_vec",  ifc.vec_idx, 1);
      chk("man_step1_caps", caps_tog + caps, 1);
      ifc.btn_step = 1'b0;
      run_count(30, caps);
      chk("man_release",    {ifc.vec_idx, caps[1:0]}, {2'd1, 2'd0});
      ifc.btn_step = 1'b1;
      run_count(30, caps);
      chk("man_step2_vec",  ifc.vec_idx, 2);
      chk("man_step2_caps", caps, 1);

      // Start while busy is ignored, then reset mid-sweep.
      pulse_start();
      cyc(3);
      chk("busy_start_ign", {ifc.busy, ifc.vec_idx}, {1'b1, 2'd2});
      rst = 1'b1;
      cyc(1);
      chk("midrst_outs", {ifc.a, ifc.b, ifc.vec_idx, ifc.busy, ifc.cap_valid}, 0);
      rst          = 1'b0;
      ifc.btn_step = 1'b0;
      cyc(1);
      pulse_start();
      chk("post_rst_start", ifc.busy, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
